// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Contents: receiver state enum, default frame parameters, oversampling
// constants and a width helper used to size counters.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned DEF_DBIT    = 8;
    localparam int unsigned DEF_SB_TICK = 16;
    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: generic two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - sampling clock
//   reset - synchronous active-high reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output (2 clk latency)
module uart_sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (start, DBIT data LSB-first,
// optional parity, stop) clocked by the shared baud tick s_tick.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   s_tick        - one-clk 16x oversample enable
//   rx            - asynchronous serial input, idles high
//   rx_dout       - last received data word
//   rx_done_tick  - one-clk pulse when a frame completes
//   frame_err     - stop bit sampled low (held until next rx_done_tick)
//   parity_err    - parity mismatch (held until next rx_done_tick)
//   busy          - high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = DEF_DBIT,
    parameter int unsigned SB_TICK    = DEF_SB_TICK,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    // Tick counter must reach SB_TICK-1 for 1.5/2 stop bits as well as 15.
    localparam int unsigned S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W = clog2_min1(DBIT);

    rx_state_t       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            armed_q, armed_d;
    logic            perr_q, perr_d;
    logic            rx_s;

    logic [DBIT-1:0] dout_d;
    logic            done_d, ferr_d, perr_out_d, busy_d;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            armed_q      <= 1'b0;
            perr_q       <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            armed_q      <= armed_d;
            perr_q       <= perr_d;
            rx_dout      <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= ferr_d;
            parity_err   <= perr_out_d;
            busy         <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        armed_d = armed_q;
        perr_d  = perr_q;
        case (state_q)
            ST_IDLE: begin
                // A falling edge only counts once the line has been seen high.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_W'(MID_SAMPLE)) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVERSAMPLE - 1)) begin
                        // Zero for a correctly formed frame of either sense.
                        perr_d  = (^b_q) ^ rx_s ^ PARITY_ODD;
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        // A low stop bit disarms until the line recovers high.
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        dout_d     = rx_dout;
        done_d     = 1'b0;
        ferr_d     = frame_err;
        perr_out_d = parity_err;
        busy_d     = (state_d != ST_IDLE);
        if (state_q == ST_STOP && s_tick && s_q == S_W'(SB_TICK - 1)) begin
            dout_d     = b_q;
            done_d     = 1'b1;
            ferr_d     = ~rx_s;
            perr_out_d = PARITY_EN ? perr_q : 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. One 8N1 instance and one 8E1
// instance share clock, reset and a 16x tick asserted every 4 clk.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx_a, rx_p;
    logic [1:0] tick_cnt = 2'd0;

    logic [7:0] dout_a, dout_p;
    logic       done_a, ferr_a, perr_a, busy_a;
    logic       done_p, ferr_p, perr_p, busy_p;

    int tests = 0;
    int fails = 0;

    // {frame_err, parity_err, rx_dout} captured per rx_done_tick
    logic [9:0] q_a[$];
    logic [9:0] q_p[$];
    int         dbl_a = 0;
    logic       prev_done_a = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign s_tick = (tick_cnt == 2'd3);

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_a),
        .rx_dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a),
        .parity_err(perr_a), .busy(busy_a)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
        .rx_dout(dout_p), .rx_done_tick(done_p), .frame_err(ferr_p),
        .parity_err(perr_p), .busy(busy_p)
    );

    always @(negedge clk) begin
        if (done_a) q_a.push_back({ferr_a, perr_a, dout_a});
        if (done_p) q_p.push_back({ferr_p, perr_p, dout_p});
        if (done_a && prev_done_a) dbl_a <= dbl_a + 1;
        prev_done_a <= done_a;
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v; else rx_a = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (with_par) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic pop_a(output logic [9:0] it);
        if (q_a.size() > 0) it = q_a.pop_front(); else it = 'x;
    endtask

    task automatic pop_p(output logic [9:0] it);
        if (q_p.size() > 0) it = q_p.pop_front(); else it = 'x;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_a = 1'b1; rx_p = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (dout_a !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", dout_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_a); end
        tests++; if (ferr_a !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", ferr_a); end
        tests++; if (perr_a !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", perr_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++; if (busy_a !== 1'b0 || busy_p !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b%b expected 00", busy_a, busy_p); end
    endtask

    task automatic test_basic();
        logic [9:0] it;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        tests++; if (q_a.size() !== 1) begin fails++; $display("FAIL basic_count: got %0d expected 1", q_a.size()); end
        pop_a(it);
        tests++; if (it !== {2'b00, 8'hA5}) begin fails++; $display("FAIL basic_frame: got %h expected %h", it, {2'b00, 8'hA5}); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_glitch();
        logic [9:0] it;
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        tests++; if (q_a.size() !== 0) begin fails++; $display("FAIL glitch_no_done: got %0d expected 0", q_a.size()); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        tests++; if (q_a.size() !== 1) begin fails++; $display("FAIL glitch_next_count: got %0d expected 1", q_a.size()); end
        pop_a(it);
        tests++; if (it !== {2'b00, 8'h5A}) begin fails++; $display("FAIL glitch_next_frame: got %h expected %h", it, {2'b00, 8'h5A}); end
    endtask

    task automatic test_frame_err();
        logic [9:0] it;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (39 * BIT_CLK) @(negedge clk);
        tests++; if (q_a.size() !== 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", q_a.size()); end
        pop_a(it);
        tests++; if (it !== {2'b10, 8'h3C}) begin fails++; $display("FAIL ferr_frame: got %h expected %h", it, {2'b10, 8'h3C}); end
        tests++; if (ferr_a !== 1'b1) begin fails++; $display("FAIL ferr_hold: got %b expected 1", ferr_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL ferr_break_busy: got %b expected 0", busy_a); end
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        tests++; if (q_a.size() !== 1) begin fails++; $display("FAIL ferr_next_count: got %0d expected 1", q_a.size()); end
        pop_a(it);
        tests++; if (it !== {2'b00, 8'h81}) begin fails++; $display("FAIL ferr_next_frame: got %h expected %h", it, {2'b00, 8'h81}); end
    endtask

    task automatic test_parity();
        logic [9:0] it;
        send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        tests++; if (q_p.size() !== 1) begin fails++; $display("FAIL par_good_count: got %0d expected 1", q_p.size()); end
        pop_p(it);
        tests++; if (it !== {2'b00, 8'h01}) begin fails++; $display("FAIL par_good: got %h expected %h", it, {2'b00, 8'h01}); end
        send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        tests++; if (q_p.size() !== 1) begin fails++; $display("FAIL par_bad_count: got %0d expected 1", q_p.size()); end
        pop_p(it);
        tests++; if (it !== {2'b01, 8'h01}) begin fails++; $display("FAIL par_bad: got %h expected %h", it, {2'b01, 8'h01}); end
        tests++; if (perr_p !== 1'b1) begin fails++; $display("FAIL par_hold: got %b expected 1", perr_p); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] it;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        rx_a = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_a); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if ({dout_a, done_a, ferr_a, perr_a, busy_a} !== 12'h000) begin fails++; $display("FAIL rstmid_outs_a: got %h expected 000", {dout_a, done_a, ferr_a, perr_a, busy_a}); end
        tests++; if ({dout_p, done_p, ferr_p, perr_p, busy_p} !== 12'h000) begin fails++; $display("FAIL rstmid_outs_p: got %h expected 000", {dout_p, done_p, ferr_p, perr_p, busy_p}); end
        rx_a = 1'b1;
        repeat (4 * BIT_CLK) @(negedge clk);
        tests++; if (q_a.size() !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d expected 0", q_a.size()); end
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        tests++; if (q_a.size() !== 1) begin fails++; $display("FAIL rstmid_next_count: got %0d expected 1", q_a.size()); end
        pop_a(it);
        tests++; if (it !== {2'b00, 8'hC3}) begin fails++; $display("FAIL rstmid_next_frame: got %h expected %h", it, {2'b00, 8'hC3}); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] it;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h55;
        for (int k = 0; k < 3; k++) send_frame(1'b0, exp_v[k], 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        tests++; if (q_a.size() !== 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", q_a.size()); end
        for (int k = 0; k < 3; k++) begin
            pop_a(it);
            tests++; if (it !== {2'b00, exp_v[k]}) begin fails++; $display("FAIL b2b_frame%0d: got %h expected %h", k, it, {2'b00, exp_v[k]}); end
        end
        tests++; if (dbl_a !== 0) begin fails++; $display("FAIL done_width: got %0d multi-cycle pulses expected 0", dbl_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: recovers frames (start, DBIT data LSB-first, optional parity, stop) from the asynchronous `rx` line using the shared 16× baud tick `s_tick`. It pairs with the existing transmitter on the same baud generator. It delivers each byte with a one-clock `rx_done_tick` plus framing and parity status, for consumption by a FIFO or host interface.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: s_ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `PARITY_EN`, 0: 1 = expect a parity bit after the data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `s_tick` in 1: 16× oversample enable, one `clk` wide.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_dout` out DBIT: last received data word.
- `rx_done_tick` out 1: one-`clk` pulse when a frame completes.
- `frame_err` out 1: stop bit sampled low, valid with `rx_done_tick`.
- `parity_err` out 1: parity mismatch, valid with `rx_done_tick`; 0 when PARITY_EN=0.
- `busy` out 1: high in every state except idle.

## Operation
- **Input synchronizer:** `rx` passes through 2 flip-flops to give `rx_s`. Both flip-flops reset to 1.
- **Registers:** state, `s` (4-bit tick count), `n` (bit index, width clog2(DBIT)), `b` (DBIT shift register), `armed`.
- **Registered outputs:** every output is registered.
- **States:**
  - **idle:**
    - `armed` sets when `rx_s`=1.
    - If `armed`=1 and `rx_s`=0, clear `s` and go to start.
  - **start:**
    - On `s_tick` with `s`=7 (mid start bit): if `rx_s`=0, clear `s` and `n` and go to data. If `rx_s`=1, treat it as a glitch and return to idle with no pulse.
    - On any other `s_tick`, increment `s`.
  - **data:**
    - On `s_tick` with `s`=15: set `b` = {`rx_s`, `b[DBIT-1:1]`} and clear `s`.
    - If `n`=DBIT-1, go to parity (when PARITY_EN=1) or stop. Otherwise increment `n`.
  - **parity:**
    - On `s_tick` with `s`=15: latch the XOR of `b` and `rx_s` into `perr_q`, inverted when PARITY_ODD=1, so that a correct frame gives `perr_q`=0.
    - Clear `s` and go to stop.
  - **stop:**
    - On `s_tick` with `s`=SB_TICK-1 (count `s` with enough width for SB_TICK):
      - `rx_dout` ← `b`
      - `frame_err` ← ~`rx_s`
      - `parity_err` ← `perr_q`
      - pulse `rx_done_tick`
      - if `rx_s`=0, clear `armed`
      - go to idle.
- **Break / stuck-low:** after a framing error, `armed` stays 0 until `rx_s`=1, so a low line never re-triggers a start.
- **Status hold:** `frame_err` and `parity_err` hold until the next `rx_done_tick`.
- **Illegal state:** any illegal state returns to idle.

## Timing
- **Reset values:**
  - `rx_dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, `busy`=0
  - state=idle, `armed`=0, synchronizer=1s.
- **Start detection latency:** 2 `clk` from an `rx` edge to `rx_s`. Start detection then needs 8 s_ticks.
- **Sample points:** each data bit is sampled 16 s_ticks after the previous sample point, i.e. at mid-bit.
- **`rx_done_tick`:** high for exactly 1 `clk`, on the `clk` after the final stop-bit `s_tick`. `rx_dout`, `frame_err` and `parity_err` are valid in that same cycle.
- **Back-to-back frames:** a new start bit beginning on the `clk` after `rx_done_tick` is accepted with no dead time.
- **Reset mid-frame:** the frame is abandoned with no `rx_done_tick`. All outputs return to their reset values on the next edge.
- **`s_tick` held high every `clk`:** legal; the block then behaves as 16× `clk` sampling.
- **`s_tick` coinciding with a state transition:** that tick is consumed by the transition. The per-state counts above are exact.

## Structure
- **Package `uart_pkg`:**
  - state enum (idle, start, data, parity, stop)
  - default DBIT=8, SB_TICK=16
  - constants OVERSAMPLE=16 and MID_SAMPLE=7.
- **Sub-module `uart_sync2`:**
  - generic 2-flop synchronizer with a reset value parameter.
  - Reused for the receiver input.
- **Remaining logic:** the FSM, counters, shifter and output registers live in `uart_rx`.

## Test plan
- **Basic frame:** 8N1 frame 0xA5 at 16 s_ticks/bit (s_tick every 4 clk) → `rx_dout`=0xA5, one `rx_done_tick`, `frame_err`=0, `parity_err`=0, `busy` low afterwards.
- **Start glitch:** `rx` low for 4 s_ticks, then high → no `rx_done_tick`, state back in idle, `busy`=0. A following 0x5A frame is received correctly.
- **Framing error:** frame 0x3C with the stop bit driven low, line held low 40 bit-times → one `rx_done_tick` with `rx_dout`=0x3C and `frame_err`=1. No further frames until `rx` returns high. The next 0x81 frame gives `frame_err`=0.
- **Parity:** PARITY_EN=1, PARITY_ODD=0, data 0x01.
  - parity bit 1 → `parity_err`=0
  - parity bit 0 → `parity_err`=1
- **Reset mid-frame:** `reset` pulsed 1 `clk` during data bit 3 → no `rx_done_tick` and all outputs 0. A following 0xC3 frame is received correctly.
- **Back-to-back:** back-to-back 0x00, 0xFF, 0x55 with zero idle gap → 3 pulses with matching `rx_dout` and no errors.
